arm_motion_seq: RTL and testbench

Waypoint sequencer for the three-servo arm. It drives the `pwm1` (joint 1), `pwm2` (joint 2) and `catch_pwm` (gripper) pulse-width words consumed by the arm PWM generators. It holds a small programmable table of waypoints and ramps all three channels toward each waypoint at a fixed slew rate. After each arrival it dwells for a fixed time, then advances to the next waypoint.

---
 rtl/arm_seq_pkg.sv | 17 +
 rtl/arm_motion_seq_if.sv | 31 +++
 rtl/arm_ramp_step.sv | 33 +++
 rtl/arm_motion_seq.sv | 154 +++++++++++++++
 tb/tb_arm_motion_seq.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_seq_pkg.sv
// Shared types and constants for the arm waypoint sequencer.
package arm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    HOLD
  } arm_state_t;

  localparam logic [1:0]  CH_PWM1  = 2'd0;
  localparam logic [1:0]  CH_PWM2  = 2'd1;
  localparam logic [1:0]  CH_CATCH = 2'd2;

  localparam logic [31:0] DEF_INIT_PW = 32'd1500;
  localparam int          DEF_STEP    = 10;

endpackage

// File: rtl/arm_motion_seq_if.sv
// Table-programming, run-control and pulse-width output bundle of the arm sequencer.
interface arm_motion_seq_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wp_wr;
  logic [AW-1:0] wp_addr;
  logic [1:0]    wp_ch;
  logic [31:0]   wp_data;
  logic [AW:0]   wp_count;
  logic          start;
  logic          abort;
  logic [31:0]   pwm1;
  logic [31:0]   pwm2;
  logic [31:0]   catch_pwm;
  logic          busy;
  logic          done;
  logic [AW-1:0] wp_idx;

  modport master (
    output wp_wr, wp_addr, wp_ch, wp_data, wp_count, start, abort,
    input  pwm1, pwm2, catch_pwm, busy, done, wp_idx
  );

  modport slave (
    input  wp_wr, wp_addr, wp_ch, wp_data, wp_count, start, abort,
    output pwm1, pwm2, catch_pwm, busy, done, wp_idx
  );

endinterface

// File: rtl/arm_ramp_step.sv
// One channel of slew limiting: next value moves toward target by at most STEP per tick.
module arm_ramp_step
  import arm_seq_pkg::*;
#(
  parameter int STEP = DEF_STEP
) (
  input  logic [31:0] cur,
  input  logic [31:0] target,
  input  logic        tick,
  output logic [31:0] next_val,
  output logic        at_target
);

  logic        up;
  logic [31:0] diff;

  always_comb begin
    up       = target > cur;
    diff     = up ? (target - cur) : (cur - target);
    next_val = cur;
    if (tick) begin
      if (diff <= 32'(STEP))
        next_val = target;
      else if (up)
        next_val = cur + 32'(STEP);
      else
        next_val = cur - 32'(STEP);
    end
  end

  assign at_target = (next_val == target);

endmodule

// File: rtl/arm_motion_seq.sv
// Waypoint sequencer ramping pwm1/pwm2/catch_pwm through a programmable table.
// Define ARM_SEQ_LOOP_EN to make the run wrap to waypoint 0 forever instead of finishing.
module arm_motion_seq
  import arm_seq_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter int          TICK_DIV   = 1000,
  parameter int          STEP       = DEF_STEP,
  parameter int          HOLD_TICKS = 50,
  parameter logic [31:0] INIT_PW    = DEF_INIT_PW
) (
  input logic             clk,
  input logic             rst_n,
  arm_motion_seq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  arm_state_t    state;
  logic [CW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic [AW:0]   run_count;
  logic [AW-1:0] wp_idx;
  logic          busy;
  logic          done;

  logic [31:0]   cur [3];
  logic [31:0]   tbl [3][DEPTH];
  logic [31:0]   tgt [3];
  logic [31:0]   nxt [3];
  logic [2:0]    at_tgt;

  logic          tick;
  logic          move_tick;
  logic          hold_last;
  logic          last_wp;

  assign tick      = busy && (tick_cnt == CW'(TICK_DIV - 1));
  assign move_tick = tick && (state == MOVE);
  assign hold_last = tick && (state == HOLD) && (hold_cnt == HW'(HOLD_TICKS - 1));
  assign last_wp   = ({1'b0, wp_idx} >= (run_count - 1'b1));

  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign tgt[i] = tbl[i][wp_idx];

    arm_ramp_step #(.STEP(STEP)) u_ramp (
      .cur       (cur[i]),
      .target    (tgt[i]),
      .tick      (move_tick),
      .next_val  (nxt[i]),
      .at_target (at_tgt[i])
    );
  end

  // Control FSM; arrival is judged on the post-update values from the ramp units.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wp_idx    <= '0;
      run_count <= '0;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (busy)
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (bus.abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.wp_count == '0) begin
                done <= 1'b1;
              end else begin
                run_count <= bus.wp_count;
                wp_idx    <= '0;
                tick_cnt  <= '0;
                state     <= MOVE;
                busy      <= 1'b1;
              end
            end
          end
          MOVE: begin
            if (move_tick && (&at_tgt)) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            if (hold_last) begin
              if (!last_wp) begin
                wp_idx <= wp_idx + 1'b1;
                state  <= MOVE;
              end else begin
`ifdef ARM_SEQ_LOOP_EN
                wp_idx <= '0;
                state  <= MOVE;
`else
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
`endif
              end
            end else if (tick) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Table writes are only accepted while idle; an abort freezes the outputs even on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        cur[c] <= INIT_PW;
        for (int a = 0; a < DEPTH; a++)
          tbl[c][a] <= INIT_PW;
      end
    end else begin
      if (move_tick && !bus.abort) begin
        for (int c = 0; c < 3; c++)
          cur[c] <= nxt[c];
      end
      if ((state == IDLE) && bus.wp_wr) begin
        case (bus.wp_ch)
          CH_PWM1:  tbl[0][bus.wp_addr] <= bus.wp_data;
          CH_PWM2:  tbl[1][bus.wp_addr] <= bus.wp_data;
          CH_CATCH: tbl[2][bus.wp_addr] <= bus.wp_data;
          default:  ;
        endcase
      end
    end
  end

  assign bus.pwm1      = cur[0];
  assign bus.pwm2      = cur[1];
  assign bus.catch_pwm = cur[2];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.wp_idx    = wp_idx;

endmodule

// File: tb/tb_arm_motion_seq.sv
// Self-checking bench for arm_motion_seq: vector table, hand sequences and a tick-level reference model.
module tb_arm_motion_seq;

  localparam int          DEPTH      = 8;
  localparam int          TICK_DIV   = 4;
  localparam int          STEP       = 100;
  localparam int          HOLD_TICKS = 2;
  localparam logic [31:0] INIT_PW    = 32'd1500;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [31:0] mt [3][DEPTH];
  logic [31:0] mp [3];

  arm_motion_seq_if #(.DEPTH(DEPTH)) bus ();

  arm_motion_seq #(
    .DEPTH      (DEPTH),
    .TICK_DIV   (TICK_DIV),
    .STEP       (STEP),
    .HOLD_TICKS (HOLD_TICKS),
    .INIT_PW    (INIT_PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] tc;
    int          cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] toward(input logic [31:0] c, input logic [31:0] t);
    if (t > c)
      return ((t - c) > STEP) ? c + STEP : t;
    else
      return ((c - t) > STEP) ? c - STEP : t;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mp[c] = INIT_PW;
      for (int a = 0; a < DEPTH; a++)
        mt[c][a] = INIT_PW;
    end
  endtask

  task automatic do_reset();
    bus.wp_wr    = 1'b0;
    bus.wp_addr  = '0;
    bus.wp_ch    = '0;
    bus.wp_data  = '0;
    bus.wp_count = '0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    rst_n        = 1'b0;
    step_cycle();
    step_cycle();
    rst_n = 1'b1;
    step_cycle();
    model_reset();
  endtask

  task automatic write_wp(input int addr, input logic [1:0] ch, input logic [31:0] data);
    bus.wp_wr   = 1'b1;
    bus.wp_addr = 3'(addr);
    bus.wp_ch   = ch;
    bus.wp_data = data;
    step_cycle();
    bus.wp_wr = 1'b0;
    if (ch != 2'd3)
      mt[ch][addr] = data;
  endtask

  task automatic start_run(input int count);
    bus.wp_count = 4'(count);
    bus.start    = 1'b1;
    step_cycle();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while ((cyc < bound) && !bus.done) begin
      step_cycle();
      cyc++;
    end
  endtask

  // Expected per-tick trajectory derived from the slew/dwell rules, checked at every tick boundary.
  task automatic run_check(input int count, input bit wos, input int waddr,
                           input logic [1:0] wch, input logic [31:0] wdata, input string tag);
    logic [31:0] p [3];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] qc [$];
    int          qi [$];
    bit          qb [$];
    bit          qd [$];
    for (int c = 0; c < 3; c++) p[c] = mp[c];
    if (wos && (wch != 2'd3)) mt[wch][waddr] = wdata;
    for (int w = 0; w < count; w++) begin
      bit arrived;
      arrived = 1'b0;
      while (!arrived) begin
        for (int c = 0; c < 3; c++) p[c] = toward(p[c], mt[c][w]);
        arrived = (p[0] == mt[0][w]) && (p[1] == mt[1][w]) && (p[2] == mt[2][w]);
        q1.push_back(p[0]); q2.push_back(p[1]); qc.push_back(p[2]);
        qi.push_back(w); qb.push_back(1'b1); qd.push_back(1'b0);
      end
      for (int h = 1; h <= HOLD_TICKS; h++) begin
        bit fin;
        bit lst;
        fin = (h == HOLD_TICKS);
        lst = (w == count - 1);
        q1.push_back(p[0]); q2.push_back(p[1]); qc.push_back(p[2]);
        qi.push_back((fin && !lst) ? w + 1 : w);
        qb.push_back(!(fin && lst));
        qd.push_back(fin && lst);
      end
    end
    bus.wp_count = 4'(count);
    bus.start    = 1'b1;
    if (wos) begin
      bus.wp_wr   = 1'b1;
      bus.wp_addr = 3'(waddr);
      bus.wp_ch   = wch;
      bus.wp_data = wdata;
    end
    step_cycle();
    bus.start = 1'b0;
    bus.wp_wr = 1'b0;
    checkOutput({tag, " busy_rise"}, 32'(bus.busy), 32'd1);
    for (int k = 0; k < q1.size(); k++) begin
      repeat (TICK_DIV) step_cycle();
      checkOutput($sformatf("%s t%0d pwm1", tag, k + 1), bus.pwm1, q1[k]);
      checkOutput($sformatf("%s t%0d pwm2", tag, k + 1), bus.pwm2, q2[k]);
      checkOutput($sformatf("%s t%0d catch", tag, k + 1), bus.catch_pwm, qc[k]);
      checkOutput($sformatf("%s t%0d idx", tag, k + 1), 32'(bus.wp_idx), 32'(qi[k]));
      checkOutput($sformatf("%s t%0d busy", tag, k + 1), 32'(bus.busy), 32'(qb[k]));
      checkOutput($sformatf("%s t%0d done", tag, k + 1), 32'(bus.done), 32'(qd[k]));
    end
    step_cycle();
    checkOutput({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    for (int c = 0; c < 3; c++) mp[c] = p[c];
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    int cyc;
    write_wp(0, 2'd0, v.t1);
    write_wp(0, 2'd1, v.t2);
    write_wp(0, 2'd2, v.tc);
    start_run(1);
    wait_done(400, cyc);
    checkOutput($sformatf("vec%0d cycles", n), 32'(cyc), 32'(v.cyc));
    checkOutput($sformatf("vec%0d pwm1", n), bus.pwm1, v.t1);
    checkOutput($sformatf("vec%0d pwm2", n), bus.pwm2, v.t2);
    checkOutput($sformatf("vec%0d catch", n), bus.catch_pwm, v.tc);
    checkOutput($sformatf("vec%0d busy", n), 32'(bus.busy), 32'd0);
    step_cycle();
    mp[0] = v.t1; mp[1] = v.t2; mp[2] = v.tc;
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, " pwm1"}, bus.pwm1, INIT_PW);
    checkOutput({tag, " pwm2"}, bus.pwm2, INIT_PW);
    checkOutput({tag, " catch"}, bus.catch_pwm, INIT_PW);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " idx"}, 32'(bus.wp_idx), 32'd0);
  endtask

  initial begin
    int          cyc;
    int          seen_done;
    logic [31:0] exp_1750 [4];
    tests = 0;
    fails = 0;
    rst_n = 1'b1;

    do_reset();
    check_reset_state("reset");

`ifdef ARM_SEQ_LOOP_EN
    begin
      int seq [$];
      int last_idx;
      write_wp(0, 2'd0, 32'd1800); write_wp(0, 2'd1, 32'd1500); write_wp(0, 2'd2, 32'd1200);
      write_wp(1, 2'd0, 32'd1500); write_wp(1, 2'd1, 32'd1500); write_wp(1, 2'd2, 32'd1500);
      start_run(2);
      seen_done = 0;
      last_idx  = int'(bus.wp_idx);
      seq.push_back(last_idx);
      cyc = 0;
      while ((cyc < 400) && (seq.size() < 4)) begin
        step_cycle();
        cyc++;
        if (bus.done) seen_done++;
        if (int'(bus.wp_idx) != last_idx) begin
          last_idx = int'(bus.wp_idx);
          seq.push_back(last_idx);
        end
      end
      checkOutput("loop seq_len", 32'(seq.size()), 32'd4);
      for (int i = 0; i < seq.size(); i++)
        checkOutput($sformatf("loop idx%0d", i), 32'(seq[i]), 32'(i % 2));
      checkOutput("loop busy", 32'(bus.busy), 32'd1);
      checkOutput("loop no_done", 32'(seen_done), 32'd0);
      bus.abort = 1'b1;
      step_cycle();
      bus.abort = 1'b0;
      checkOutput("loop abort busy", 32'(bus.busy), 32'd0);
      checkOutput("loop abort done", 32'(bus.done), 32'd0);
    end
`else
    vecs[0] = '{32'd1800, 32'd1500, 32'd1200, 20};
    vecs[1] = '{32'd1750, 32'd1500, 32'd1200, 12};
    vecs[2] = '{32'd1750, 32'd1500, 32'd1200, 12};
    vecs[3] = '{32'd1000, 32'd2000, 32'd1250, 40};
    vecs[4] = '{32'd0,    32'd2000, 32'd1250, 48};
    vecs[5] = '{32'd1500, 32'd1500, 32'd1500, 68};
    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i], i);

    do_reset();
    write_wp(0, 2'd0, 32'd1800); write_wp(0, 2'd1, 32'd1500); write_wp(0, 2'd2, 32'd1200);
    run_check(1, 1'b0, 0, 2'd0, 32'd0, "basic");

    do_reset();
    exp_1750[0] = 32'd1600; exp_1750[1] = 32'd1700; exp_1750[2] = 32'd1750; exp_1750[3] = 32'd1750;
    write_wp(0, 2'd0, 32'd1750);
    start_run(1);
    for (int k = 0; k < 4; k++) begin
      repeat (TICK_DIV) step_cycle();
      checkOutput($sformatf("nonmult t%0d", k + 1), bus.pwm1, exp_1750[k]);
    end
    wait_done(100, cyc);
    checkOutput("nonmult done_seen", 32'(bus.done), 32'd1);
    step_cycle();

    do_reset();
    write_wp(0, 2'd0, 32'd1800); write_wp(0, 2'd1, 32'd1500); write_wp(0, 2'd2, 32'd1200);
    write_wp(1, 2'd0, 32'd1500); write_wp(1, 2'd1, 32'd1500); write_wp(1, 2'd2, 32'd1500);
    run_check(2, 1'b0, 0, 2'd0, 32'd0, "two_wp");

    do_reset();
    write_wp(0, 2'd0, 32'd1800); write_wp(0, 2'd1, 32'd1500); write_wp(0, 2'd2, 32'd1200);
    start_run(1);
    repeat (2 * TICK_DIV) step_cycle();
    checkOutput("abort pre pwm1", bus.pwm1, 32'd1700);
    bus.abort = 1'b1;
    step_cycle();
    bus.abort = 1'b0;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort pwm1", bus.pwm1, 32'd1700);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    seen_done = 0;
    repeat (20) begin
      step_cycle();
      if (bus.done) seen_done++;
    end
    checkOutput("abort no_done", 32'(seen_done), 32'd0);
    checkOutput("abort frozen", bus.pwm1, 32'd1700);
    mp[0] = 32'd1700; mp[1] = 32'd1500; mp[2] = 32'd1300;
    run_check(1, 1'b0, 0, 2'd0, 32'd0, "resume");

    start_run(0);
    checkOutput("cnt0 done", 32'(bus.done), 32'd1);
    checkOutput("cnt0 busy", 32'(bus.busy), 32'd0);
    step_cycle();
    checkOutput("cnt0 done_low", 32'(bus.done), 32'd0);
    checkOutput("cnt0 busy_low", 32'(bus.busy), 32'd0);

    start_run(1);
    bus.wp_wr = 1'b1; bus.wp_addr = '0; bus.wp_ch = 2'd0; bus.wp_data = 32'd1000;
    step_cycle();
    bus.wp_wr = 1'b0;
    wait_done(100, cyc);
    checkOutput("busywr cycles", 32'(cyc + 1), 32'(3 * TICK_DIV));
    step_cycle();
    run_check(1, 1'b0, 0, 2'd0, 32'd0, "busywr");
    write_wp(0, 2'd3, 32'd1000);
    run_check(1, 1'b0, 0, 2'd0, 32'd0, "ch3wr");

    write_wp(0, 2'd0, 32'd1000);
    start_run(1);
    repeat (6) step_cycle();
    rst_n = 1'b0;
    #2;
    checkOutput("async pwm1", bus.pwm1, INIT_PW);
    checkOutput("async busy", 32'(bus.busy), 32'd0);
    checkOutput("async idx", 32'(bus.wp_idx), 32'd0);
    do_reset();
    run_check(1, 1'b0, 0, 2'd0, 32'd0, "table_reverted");

    for (int r = 0; r < 5; r++) begin
      int cnt;
      cnt = int'($urandom_range(1, 3));
      for (int w = 0; w < cnt; w++)
        for (int c = 0; c < 3; c++)
          if (!((w == cnt - 1) && (c == 2)))
            write_wp(w, 2'(c), 32'($urandom_range(900, 2100)));
      run_check(cnt, 1'b1, cnt - 1, 2'd2, 32'($urandom_range(900, 2100)), $sformatf("rand%0d", r));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
